// File: rtl/median_pkg.sv
// Shared mode encodings and the stage-2 payload type for median_filter_pipe.
// The payload fields are PIX_W wide, so the filter's DW is expected to equal PIX_W.
package median_pkg;

   localparam logic [1:0] MODE_MIN  = 2'd0;
   localparam logic [1:0] MODE_MAX  = 2'd1;
   localparam logic [1:0] MODE_AMED = 2'd2;
   localparam logic [1:0] MODE_EMED = 2'd3;

   localparam int unsigned PIX_W = 8;

   typedef struct packed {
      logic [PIX_W-1:0] min;
      logic [PIX_W-1:0] max;
      logic [PIX_W-1:0] amed;
      logic [PIX_W-1:0] emed;
      logic [1:0]       mode;
   } s2_pay_t;

endpackage

// File: rtl/sort3.sv
// Combinational 3-input unsigned sorter; equal values keep their input order.
module sort3 #(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   output logic [DW-1:0] lo,
   output logic [DW-1:0] mid,
   output logic [DW-1:0] hi
);

   logic [DW-1:0] x0, x1, y1, y2;

   // Strict compares, so a tie never swaps and the lower-index operand stays low.
   always_comb begin
      x0  = (a > b) ? b : a;
      x1  = (a > b) ? a : b;
      y1  = (x1 > c) ? c : x1;
      y2  = (x1 > c) ? x1 : c;
      lo  = (x0 > y1) ? y1 : x0;
      mid = (x0 > y1) ? x0 : y1;
      hi  = y2;
   end

endmodule

// File: rtl/median_filter_pipe.sv
// 3-stage elastic min/max/median filter over a 3x3 window with valid/ready handshakes.
// Define EXACT_MEDIAN_EN to make mode 3 the true median of 9 rather than the row-median estimate.
module median_filter_pipe
   import median_pkg::*;
#(
   parameter int unsigned DW    = PIX_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [9*DW-1:0]   in_win,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_pix,
   output logic [1:0]        out_mode,
   output logic [CNT_W-1:0]  win_cnt
);

   logic [2:0][DW-1:0] row_lo, row_mid, row_hi;
   logic [2:0][DW-1:0] lo_q, lo_d, mid_q, mid_d, hi_q, hi_d;
   logic [1:0]         m1_q, m1_d;
   logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   s2_pay_t            s2_q, s2_d, s2_new;
   logic [DW-1:0]      pix_q, pix_d;
   logic [1:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ld1, ld2, ld3;
   logic [DW-1:0]      c0_lo, c0_mid, c0_hi, c1_lo, c1_mid, c1_hi, c2_lo, c2_mid, c2_hi;
   logic [DW-1:0]      emed;
   logic               unused_sort;

   for (genvar r = 0; r < 3; r++) begin : g_row
      sort3 #(.DW(DW)) u_row (
         .a   (in_win[(3*r)*DW +: DW]),
         .b   (in_win[(3*r+1)*DW +: DW]),
         .c   (in_win[(3*r+2)*DW +: DW]),
         .lo  (row_lo[r]),
         .mid (row_mid[r]),
         .hi  (row_hi[r])
      );
   end

   // Column sorts of the row-sorted matrix; col0.lo is the min and col2.hi the max.
   sort3 #(.DW(DW)) u_col0 (
      .a(lo_q[0]), .b(lo_q[1]), .c(lo_q[2]), .lo(c0_lo), .mid(c0_mid), .hi(c0_hi)
   );
   sort3 #(.DW(DW)) u_col1 (
      .a(mid_q[0]), .b(mid_q[1]), .c(mid_q[2]), .lo(c1_lo), .mid(c1_mid), .hi(c1_hi)
   );
   sort3 #(.DW(DW)) u_col2 (
      .a(hi_q[0]), .b(hi_q[1]), .c(hi_q[2]), .lo(c2_lo), .mid(c2_mid), .hi(c2_hi)
   );

`ifdef EXACT_MEDIAN_EN
   logic [DW-1:0] e_lo, e_hi;

   // Median of the anti-diagonal of the fully sorted matrix is the median of all nine.
   sort3 #(.DW(DW)) u_emed (
      .a(c0_hi), .b(c1_mid), .c(c2_lo), .lo(e_lo), .mid(emed), .hi(e_hi)
   );
   assign unused_sort = ^{c0_mid, c1_lo, c1_hi, c2_mid, e_lo, e_hi};
`else
   assign emed        = c1_mid;
   assign unused_sort = ^{c0_mid, c0_hi, c1_lo, c1_hi, c2_lo, c2_mid};
`endif

   always_comb begin
      ld3    = !v3_q || out_ready;
      ld2    = !v2_q || ld3;
      ld1    = !v1_q || ld2;
      s2_new = '{min: c0_lo, max: c2_hi, amed: c1_mid, emed: emed, mode: m1_q};

      v1_d   = v1_q;
      v2_d   = v2_q;
      v3_d   = v3_q;
      lo_d   = lo_q;
      mid_d  = mid_q;
      hi_d   = hi_q;
      m1_d   = m1_q;
      s2_d   = s2_q;
      pix_d  = pix_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;

      if (ld1) begin
         v1_d = in_valid;
         if (in_valid) begin
            lo_d  = row_lo;
            mid_d = row_mid;
            hi_d  = row_hi;
            m1_d  = in_mode;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (ld2) begin
         v2_d = v1_q;
         if (v1_q) s2_d = s2_new;
      end

      if (ld3) begin
         v3_d = v2_q;
         if (v2_q) begin
            mode_d = s2_q.mode;
            case (s2_q.mode)
               MODE_MIN:  pix_d = s2_q.min;
               MODE_MAX:  pix_d = s2_q.max;
               MODE_AMED: pix_d = s2_q.amed;
               default:   pix_d = s2_q.emed;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         lo_q   <= '0;
         mid_q  <= '0;
         hi_q   <= '0;
         m1_q   <= '0;
         s2_q   <= '0;
         pix_q  <= '0;
         mode_q <= '0;
         cnt_q  <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         lo_q   <= lo_d;
         mid_q  <= mid_d;
         hi_q   <= hi_d;
         m1_q   <= m1_d;
         s2_q   <= s2_d;
         pix_q  <= pix_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
      end
   end

   assign in_ready  = ld1;
   assign out_valid = v3_q;
   assign out_pix   = pix_q;
   assign out_mode  = mode_q;
   assign win_cnt   = cnt_q;

endmodule
